// File: rtl/calc_hamming.sv
// -----------------------------------------------------------------------------
// calc_hamming / slice_adder
//
// Purpose: registered population count (Hamming weight) of a 32-bit word.
//   The word is split into eight nibbles, each counted by a combinational
//   slice_adder. The nibble counts are summed by a three-level unsigned adder
//   tree, and the total is captured in the single RESULT register one clock
//   after DATA is presented.
//
// slice_adder ports:
//   slice  in  [3:0]  nibble to count
//   sum    out [2:0]  number of set bits in slice (0..4)
//
// calc_hamming ports:
//   CLK     in         clock, all state updates on the rising edge
//   RST     in         synchronous active-high reset, clears RESULT
//   DATA    in  [31:0] word whose set bits are counted
//   RESULT  out [5:0]  registered count of set bits (0..32)
// -----------------------------------------------------------------------------

module slice_adder (
  input  logic [3:0] slice,
  output logic [2:0] sum
);

  // Count the four bits of the nibble; each bit is widened so the sum cannot wrap.
  always_comb begin
    sum = {2'b00, slice[0]} + {2'b00, slice[1]} +
          {2'b00, slice[2]} + {2'b00, slice[3]};
  end

endmodule

module calc_hamming (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  output logic [5:0]  RESULT
);

  logic [2:0] w_slice_sum [0:7];
  logic [3:0] w_pair_sum  [0:3];
  logic [4:0] w_quad_sum  [0:1];
  logic [5:0] w_total;
  logic [5:0] r_result;

  genvar gi;

  // One counter per nibble; instance i covers DATA[4i+3:4i].
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      slice_adder u_slice_adder (
        .slice (DATA[4*gi +: 4]),
        .sum   (w_slice_sum[gi])
      );
    end
  endgenerate

  // Adder tree: each level is one bit wider than its operands, so a full
  // word of ones reaches the register as 6'b100000 without truncation.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_pair_sum[i] = {1'b0, w_slice_sum[2*i]} + {1'b0, w_slice_sum[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      w_quad_sum[i] = {1'b0, w_pair_sum[2*i]} + {1'b0, w_pair_sum[2*i+1]};
    end
    w_total = {1'b0, w_quad_sum[0]} + {1'b0, w_quad_sum[1]};
  end

  // Result register; reset wins over the count presented at the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result <= 6'd0;
    end else begin
      r_result <= w_total;
    end
  end

  assign RESULT = r_result;

endmodule

// File: tb/tb_calc_hamming.sv
// -----------------------------------------------------------------------------
// tb_calc_hamming: self-checking bench for calc_hamming.
// Expected counts come from a bit-counting reference function; DATA is driven
// 1 time unit after each rising edge and RESULT is sampled at that same point,
// before the next DATA value is applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_calc_hamming;

  logic        CLK;
  logic        RST;
  logic [31:0] DATA;
  logic [5:0]  RESULT;

  logic [3:0]  tb_slice;
  logic [2:0]  tb_slice_sum;

  int n_checks;
  int n_fail;

  calc_hamming u_dut (
    .CLK    (CLK),
    .RST    (RST),
    .DATA   (DATA),
    .RESULT (RESULT)
  );

  slice_adder u_slice (
    .slice (tb_slice),
    .sum   (tb_slice_sum)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: count set bits one position at a time.
  function automatic logic [31:0] ref_popcount(input logic [31:0] w);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (w[i] == 1'b1) n = n + 32'd1;
    end
    return n;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one word, clock it in, and check RESULT one edge later.
  task automatic apply_word(input string tag, input logic [31:0] w);
    DATA = w;
    @(posedge CLK);
    #1;
    check_val(tag, {26'd0, RESULT}, ref_popcount(w));
  endtask

  logic [31:0] directed_tbl [0:6];
  logic [31:0] directed_exp [0:6];
  logic [31:0] word_r;
  logic [31:0] held_v;

  // Watchdog so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    DATA     = 32'hFFFF_FFFF;
    tb_slice = 4'd0;

    // Reset clears RESULT even with a full word on DATA.
    @(posedge CLK);
    #1;
    check_val("reset_state", {26'd0, RESULT}, 32'd0);
    RST = 1'b0;

    // First edge after reset release loads the count with no extra delay.
    @(posedge CLK);
    #1;
    check_val("reset_release", {26'd0, RESULT}, 32'd32);

    // Directed vectors with hand-derived expected counts.
    directed_tbl[0] = 32'h0000_0000; directed_exp[0] = 32'd0;
    directed_tbl[1] = 32'hFFFF_FFFF; directed_exp[1] = 32'd32;
    directed_tbl[2] = 32'hAAAA_AAAA; directed_exp[2] = 32'd16;
    directed_tbl[3] = 32'h0000_0001; directed_exp[3] = 32'd1;
    directed_tbl[4] = 32'h8000_0000; directed_exp[4] = 32'd1;
    directed_tbl[5] = 32'h0000_000F; directed_exp[5] = 32'd4;
    directed_tbl[6] = 32'hF0F0_F0F0; directed_exp[6] = 32'd16;
    for (int i = 0; i < 7; i++) begin
      DATA = directed_tbl[i];
      @(posedge CLK);
      #1;
      check_val($sformatf("directed_%0d", i), {26'd0, RESULT}, directed_exp[i]);
      $display("vector %0d %h -> %0d : %s", i, directed_tbl[i], RESULT,
               (RESULT == directed_exp[i][5:0]) ? "TRUE" : "FALSE");
    end

    // RESULT holds between edges while DATA changes.
    DATA = 32'h0000_0007;
    @(posedge CLK);
    #1;
    held_v = {26'd0, RESULT};
    check_val("hold_load", held_v, 32'd3);
    DATA = 32'hFFFF_FFFF;
    #3;
    check_val("hold_mid_cycle", {26'd0, RESULT}, 32'd3);

    // Reset with a full word, then resume.
    DATA = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    check_val("seq_full", {26'd0, RESULT}, 32'd32);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_val("seq_reset_edge", {26'd0, RESULT}, 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_val("seq_resume", {26'd0, RESULT}, 32'd32);

    // Walking one across every bit position.
    for (int i = 0; i < 32; i++) begin
      word_r = 32'd1 << i;
      apply_word($sformatf("walk1_%0d", i), word_r);
    end

    // Random sweep, back-to-back one word per cycle.
    for (int i = 0; i < 1200; i++) begin
      word_r = $urandom();
      if (i % 7 == 3) word_r = word_r & $urandom();
      if (i % 11 == 5) word_r = word_r | $urandom();
      apply_word("random", word_r);
    end

    // Permutations of a word's bits give the same count.
    for (int i = 0; i < 20; i++) begin
      word_r = $urandom();
      apply_word("perm_base", word_r);
      word_r = (word_r << (i + 1)) | (word_r >> (31 - i));
      apply_word("perm_rot", word_r);
    end

    // Standalone slice_adder over every nibble value.
    for (int i = 0; i < 16; i++) begin
      tb_slice = i[3:0];
      #1;
      check_val($sformatf("slice_%0d", i), {29'd0, tb_slice_sum},
                ref_popcount({28'd0, tb_slice}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
